// File: rtl/mult_pipe.sv
// Fully pipelined XLEN x XLEN multiplier covering MUL/MULH/MULHSU/MULHU.
// Each stage folds NUM_BITS multiplier bits into the running product; tags ride along.
module mult_pipe #(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = 6
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         in_func,
    input  logic [XLEN-1:0]                    in_a,
    input  logic [XLEN-1:0]                    in_b,
    input  logic [TAG_W-1:0]                   in_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [XLEN-1:0]                    out_result,
    output logic [TAG_W-1:0]                   out_tag,
    output logic [$clog2(NUM_STAGE+1)-1:0]     occupancy
);
    localparam int W2    = 2 * XLEN;
    localparam int NB    = W2 / NUM_STAGE;
    localparam int OCC_W = $clog2(NUM_STAGE + 1);

    logic [NUM_STAGE-1:0] valid_q;
    logic [1:0]           func_q   [NUM_STAGE];
    logic [TAG_W-1:0]     tag_q    [NUM_STAGE];
    logic [W2-1:0]        mcand_q  [NUM_STAGE];
    logic [W2-1:0]        mplier_q [NUM_STAGE];
    logic [W2-1:0]        prod_q   [NUM_STAGE];

    logic [NUM_STAGE-1:0] src_valid;
    logic [1:0]           src_func   [NUM_STAGE];
    logic [TAG_W-1:0]     src_tag    [NUM_STAGE];
    logic [W2-1:0]        src_mcand  [NUM_STAGE];
    logic [W2-1:0]        src_mplier [NUM_STAGE];
    logic [W2-1:0]        src_prod   [NUM_STAGE];
    logic [W2-1:0]        nxt_mcand  [NUM_STAGE];
    logic [W2-1:0]        nxt_mplier [NUM_STAGE];
    logic [W2-1:0]        nxt_prod   [NUM_STAGE];

    logic [NUM_STAGE-1:0] adv;
    logic                 all_full;
    logic                 a_signed;
    logic                 b_signed;
    logic [W2-1:0]        a_ext;
    logic [W2-1:0]        b_ext;
    logic                 accept;
    logic                 drain;
    logic [OCC_W-1:0]     occ_q;

    // Valid/ready: a transfer happens on an edge where valid and ready are both high;
    // ready never depends on valid. Stage k may load whenever it is empty or every
    // stage downstream of it can move, so an empty stage always accepts.
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            adv[k]   = !all_full || out_ready;
        end
    end

    always_comb begin
        a_signed = (in_func == 2'b01) || (in_func == 2'b10);
        b_signed = (in_func == 2'b01);
        a_ext    = {{XLEN{a_signed & in_a[XLEN-1]}}, in_a};
        b_ext    = {{XLEN{b_signed & in_b[XLEN-1]}}, in_b};
    end

    always_comb begin
        src_valid     = '0;
        src_valid[0]  = in_valid;
        src_func[0]   = in_func;
        src_tag[0]    = in_tag;
        src_mcand[0]  = a_ext;
        src_mplier[0] = b_ext;
        src_prod[0]   = '0;
        for (int k = 1; k < NUM_STAGE; k++) begin
            src_valid[k]  = valid_q[k-1];
            src_func[k]   = func_q[k-1];
            src_tag[k]    = tag_q[k-1];
            src_mcand[k]  = mcand_q[k-1];
            src_mplier[k] = mplier_q[k-1];
            src_prod[k]   = prod_q[k-1];
        end
        for (int k = 0; k < NUM_STAGE; k++) begin
            nxt_prod[k]   = src_prod[k] + W2'(src_mplier[k][NB-1:0]) * src_mcand[k];
            nxt_mplier[k] = src_mplier[k] >> NB;
            nxt_mcand[k]  = src_mcand[k] << NB;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                func_q[k]   <= '0;
                tag_q[k]    <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
                prod_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGE; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                // Data follows adv even during flush; the cleared valid masks it.
                if (adv[k]) begin
                    func_q[k]   <= src_func[k];
                    tag_q[k]    <= src_tag[k];
                    mcand_q[k]  <= nxt_mcand[k];
                    mplier_q[k] <= nxt_mplier[k];
                    prod_q[k]   <= nxt_prod[k];
                end
            end
        end
    end

    assign accept = in_valid && adv[0] && !flush;
    assign drain  = valid_q[NUM_STAGE-1] && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (accept && !drain) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (drain && !accept) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign in_ready   = adv[0];
    assign out_valid  = valid_q[NUM_STAGE-1];
    assign out_tag    = tag_q[NUM_STAGE-1];
    assign out_result = (func_q[NUM_STAGE-1] == 2'b00) ? prod_q[NUM_STAGE-1][XLEN-1:0]
                                                       : prod_q[NUM_STAGE-1][W2-1:XLEN];
    assign occupancy  = occ_q;

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, fully pipelined XLEN×XLEN integer multiplier for the execute stage. It implements all four RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU) and carries a tag alongside each operation. Every stage has its own valid/ready handshake and bubble collapsing, and the whole pipe can be cleared by a flush. It replaces the fixed-sign, start/done multiplier behind the multiply reservation station.

## Interface
- XLEN, 32, operand and result width.
- NUM_STAGE, 4, pipeline depth. Must divide 2*XLEN. Each stage consumes NUM_BITS = 2*XLEN/NUM_STAGE multiplier bits.
- TAG_W, 6, width of the passthrough tag (ROB index).
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all in-flight ops (mispredict squash).
- in_valid  in  1  request present.
- in_ready  out  1  stage 1 can accept this cycle.
- in_func  in  2  op select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a  in  XLEN  multiplicand (rs1).
- in_b  in  XLEN  multiplier (rs2).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present in last stage.
- out_ready  in  1  consumer (CDB arbiter) takes the result.
- out_result  out  XLEN  selected half of the product.
- out_tag  out  TAG_W  tag of out_result.
- occupancy  out  $clog2(NUM_STAGE+1)  number of valid ops in the pipe.

## Operation
- Accept at the rising edge when in_valid && in_ready && !flush.
- Operand extension to 2*XLEN:
  - a is sign-extended for MULH and MULHSU; zero-extended otherwise.
  - b is sign-extended for MULH only; zero-extended otherwise.
- Each stage register holds: valid, func, tag, shifted mcand, shifted mplier, and accumulated product.
- Stage k adds (mplier[NUM_BITS-1:0] * mcand) to the product. It shifts mplier right by NUM_BITS (zero fill) and mcand left by NUM_BITS.
- The product is complete in stage NUM_STAGE. All arithmetic is modulo 2^(2*XLEN).
- out_result selection from the last-stage register:
  - MUL: product[XLEN-1:0].
  - All others: product[2*XLEN-1:XLEN].
- Handshake:
  - adv_N = !valid_N || out_ready.
  - adv_k = !valid_k || adv_{k+1}.
  - in_ready = adv_1.
  - A stage loads from its predecessor only when adv_k. Otherwise it holds all fields.
- Bubble collapsing: an empty stage always accepts, even while the output is stalled.
- Ops never reorder, duplicate or drop, except under flush.
- occupancy = popcount of stage valids, maintained as a counter:
  - +1 on accept.
  - −1 on out_valid && out_ready.
  - Unchanged when both happen in the same cycle.
  - 0 on flush.
- Flush:
  - Clears every valid bit and occupancy at the edge.
  - Beats accept in the same cycle: no op is taken.
  - An output handshake in the flush cycle counts as consumed by the receiver.
  - Data fields need not clear.
- Reset (reset_n low, asynchronous): all valids 0, occupancy 0, out_result 0, out_tag 0.
  - in_ready reads 1 while in reset and afterwards (combinational from valids).

## Timing
- Latency without stall: an op accepted at edge t gives out_valid high after edge t+NUM_STAGE−1. It is consumed at the first later edge with out_ready.
- Throughput: one op per cycle while out_ready is held high.
- in_ready is combinational on out_ready and the stage valids. There is no combinational path from in_valid or in_a/in_b to any output.
- out_valid, out_result, out_tag and occupancy come directly from registers.
- Stall: out_valid, out_result and out_tag stay stable until the handshake completes.
- With out_ready low, up to NUM_STAGE ops fill the pipe before in_ready drops. in_ready drops in the cycle all stages are valid.
- Reset deasserted mid-stream: the pipe is empty and in_ready is 1. The first accept is allowed at the first edge after deassertion.

## Test plan
- MUL: a=0xFFFFFFF9 (−7), b=3 → out_result 0xFFFFFFEB. out_tag matches the input, and out_valid rises NUM_STAGE−1 edges after accept.
- High-half ops with a=b=0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - MULH 0x80000000×0x80000000 → 0x40000000.
- Back-to-back and backpressure: issue 10 ops (tags 0..9) with out_ready=0 for 6 cycles, then 1.
  - in_ready drops after 4 accepts and occupancy reaches 4.
  - Results emerge in tag order with no loss, then one per cycle.
- Bubble collapse: issue op A; stall the output; issue op B three cycles later. B advances into the empty stages and the pipe holds A,B adjacent. occupancy is 2.
- Flush with 3 ops in flight and in_valid=1 in the same cycle → no out_valid afterwards, occupancy 0, in_ready 1. An op issued next cycle completes normally.
- Assert reset_n low asynchronously mid-stream → out_valid and occupancy are 0 immediately, without waiting for a clock edge. After release, a random MUL/MULH/MULHSU/MULHU sweep of 10k ops matches the reference model. The sweep is repeated with NUM_STAGE=2 and 8, and with XLEN=64.
